// File: rtl/johnson_code_monitor.sv
// -----------------------------------------------------------------------------
// johnson_code_monitor
//   Receive-side decoder and health monitor for an N-stage Johnson counter.
//   Each enabled CLK edge samples JIN, decodes it to a sequence index, checks
//   that the code is legal and that the step from the previous code is legal,
//   and tracks lock to a well-behaved counter.
//
// Ports
//   CLK        in   1      clock, rising edge
//   PRESET     in   1      asynchronous active-high reset
//   EN         in   1      sample enable
//   JIN        in   N      Johnson-coded input (bit 0 is fed by inverted MSB)
//   CLR_ERR    in   1      synchronous clear of ERR_CNT (wins over increment)
//   INDEX      out  W      index of the last legal code, 0..2N-1
//   VALID_CODE out  1      legality of the most recent sample
//   LOCKED     out  1      monitor locked to the sequence
//   STEP_ERR   out  1      one-cycle pulse on illegal code/step while locked
//   WRAP       out  1      one-cycle pulse on locked step 2N-1 -> 0
//   ERR_CNT    out  ERR_W  saturating count of STEP_ERR events
// -----------------------------------------------------------------------------
module johnson_code_monitor #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic                     CLK,
  input  logic                     PRESET,
  input  logic                     EN,
  input  logic [N-1:0]             JIN,
  input  logic                     CLR_ERR,
  output logic [$clog2(2*N)-1:0]   INDEX,
  output logic                     VALID_CODE,
  output logic                     LOCKED,
  output logic                     STEP_ERR,
  output logic                     WRAP,
  output logic [ERR_W-1:0]         ERR_CNT
);

  localparam int W   = $clog2(2*N);
  localparam int LCW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT);

  typedef enum logic [0:0] {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  // Returns {legal, index}. Codes with MSB=0 are a run of ones from bit 0;
  // codes with MSB=1 are all-ones with a run of zeros from bit 0.
  function automatic logic [W:0] decode(input logic [N-1:0] code);
    int            ones;
    int            zeros;
    logic [N-1:0]  mask;
    logic [W-1:0]  idx;
    ones = 0;
    for (int i = 0; i < N; i++) begin
      ones = ones + int'(code[i]);
    end
    zeros = N - ones;
    mask  = {N{1'b0}};
    if (code[N-1] == 1'b0) begin
      for (int i = 0; i < N; i++) begin
        mask[i] = (i < ones);
      end
      idx = W'(ones);
    end else begin
      for (int i = 0; i < N; i++) begin
        mask[i] = (i >= zeros);
      end
      idx = W'(N + zeros);
    end
    return {(code == mask), idx};
  endfunction

  state_t           r_state;
  logic [W-1:0]     r_index;
  logic             r_valid;
  logic             r_have_prev;
  logic [LCW-1:0]   r_lock_cnt;
  logic             r_step_err;
  logic             r_wrap;
  logic [ERR_W-1:0] r_err_cnt;

  state_t           w_state_nxt;
  logic [W-1:0]     w_index_nxt;
  logic             w_valid_nxt;
  logic             w_have_prev_nxt;
  logic [LCW-1:0]   w_lock_cnt_nxt;
  logic             w_step_err_nxt;
  logic             w_wrap_nxt;
  logic [ERR_W-1:0] w_err_cnt_nxt;

  logic [W:0]       w_dec;
  logic             w_legal;
  logic [W-1:0]     w_idx;
  logic [W-1:0]     w_prev_inc;
  logic             w_succ;
  logic             w_hold;
  logic [ERR_W-1:0] w_err_inc;

  // Decode the sample and classify the step against the stored index.
  always_comb begin
    w_dec      = decode(JIN);
    w_legal    = w_dec[W];
    w_idx      = w_dec[W-1:0];
    w_prev_inc = (r_index == W'(2*N-1)) ? {W{1'b0}} : (r_index + W'(1));
    w_succ     = r_have_prev & w_legal & (w_idx == w_prev_inc);
    w_hold     = r_have_prev & w_legal & (w_idx == r_index);
    w_err_inc  = (r_err_cnt == {ERR_W{1'b1}}) ? r_err_cnt : (r_err_cnt + ERR_W'(1));
  end

  // Next-state and next-output logic for the lock FSM and its datapath.
  always_comb begin
    w_state_nxt     = r_state;
    w_index_nxt     = r_index;
    w_valid_nxt     = r_valid;
    w_have_prev_nxt = r_have_prev;
    w_lock_cnt_nxt  = r_lock_cnt;
    w_step_err_nxt  = 1'b0;
    w_wrap_nxt      = 1'b0;
    w_err_cnt_nxt   = r_err_cnt;

    if (EN) begin
      w_valid_nxt = w_legal;
      if (w_legal) begin
        w_index_nxt     = w_idx;
        w_have_prev_nxt = 1'b1;
      end else begin
        w_index_nxt     = r_index;
      end

      case (r_state)
        S_HUNT: begin
          if (w_succ) begin
            if (r_lock_cnt == LCW'(LOCK_CNT - 1)) begin
              w_state_nxt    = S_LOCKED;
              w_lock_cnt_nxt = {LCW{1'b0}};
            end else begin
              w_lock_cnt_nxt = r_lock_cnt + LCW'(1);
            end
          end else if (w_hold) begin
            w_lock_cnt_nxt = r_lock_cnt;
          end else begin
            // Illegal code, bad step, or the very first legal sample.
            w_lock_cnt_nxt = {LCW{1'b0}};
          end
        end
        S_LOCKED: begin
          if (w_succ) begin
            w_wrap_nxt = (r_index == W'(2*N-1));
          end else if (w_hold) begin
            w_wrap_nxt = 1'b0;
          end else begin
            w_step_err_nxt = 1'b1;
            w_err_cnt_nxt  = w_err_inc;
            w_state_nxt    = S_HUNT;
            w_lock_cnt_nxt = {LCW{1'b0}};
          end
        end
        default: begin
          w_state_nxt    = S_HUNT;
          w_lock_cnt_nxt = {LCW{1'b0}};
        end
      endcase
    end else begin
      w_valid_nxt = r_valid;
    end

    // Clear takes priority over a same-edge increment.
    if (CLR_ERR) begin
      w_err_cnt_nxt = {ERR_W{1'b0}};
    end else begin
      w_err_cnt_nxt = w_err_cnt_nxt;
    end
  end

  // State and output registers; PRESET discards all history.
  always_ff @(posedge CLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= S_HUNT;
      r_index     <= {W{1'b0}};
      r_valid     <= 1'b0;
      r_have_prev <= 1'b0;
      r_lock_cnt  <= {LCW{1'b0}};
      r_step_err  <= 1'b0;
      r_wrap      <= 1'b0;
      r_err_cnt   <= {ERR_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_index     <= w_index_nxt;
      r_valid     <= w_valid_nxt;
      r_have_prev <= w_have_prev_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_step_err  <= w_step_err_nxt;
      r_wrap      <= w_wrap_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  assign INDEX      = r_index;
  assign VALID_CODE = r_valid;
  assign LOCKED     = (r_state == S_LOCKED);
  assign STEP_ERR   = r_step_err;
  assign WRAP       = r_wrap;
  assign ERR_CNT    = r_err_cnt;

endmodule

// File: tb/tb_johnson_code_monitor.sv
// -----------------------------------------------------------------------------
// tb_johnson_code_monitor
//   Directed bench. Two instances share stimulus: dut (ERR_W=8) and dut_w2
//   (ERR_W=2) for the saturation scenario. Outputs are sampled 1 time unit
//   after the rising edge.
// -----------------------------------------------------------------------------
module tb_johnson_code_monitor;

  logic       CLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       EN = 1'b0;
  logic       CLR_ERR = 1'b0;
  logic [3:0] JIN = 4'b0000;

  logic [2:0] INDEX;
  logic       VALID_CODE, LOCKED, STEP_ERR, WRAP;
  logic [7:0] ERR_CNT;

  logic [2:0] b_index;
  logic       b_valid, b_locked, b_step, b_wrap;
  logic [1:0] b_err;

  int errors = 0;
  int checks = 0;
  int cur = 0;

  logic [3:0] jc [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                         4'b1111, 4'b1110, 4'b1100, 4'b1000};

  johnson_code_monitor #(.N(4), .LOCK_CNT(3), .ERR_W(8)) dut (
    .CLK(CLK), .PRESET(PRESET), .EN(EN), .JIN(JIN), .CLR_ERR(CLR_ERR),
    .INDEX(INDEX), .VALID_CODE(VALID_CODE), .LOCKED(LOCKED),
    .STEP_ERR(STEP_ERR), .WRAP(WRAP), .ERR_CNT(ERR_CNT)
  );

  johnson_code_monitor #(.N(4), .LOCK_CNT(3), .ERR_W(2)) dut_w2 (
    .CLK(CLK), .PRESET(PRESET), .EN(EN), .JIN(JIN), .CLR_ERR(CLR_ERR),
    .INDEX(b_index), .VALID_CODE(b_valid), .LOCKED(b_locked),
    .STEP_ERR(b_step), .WRAP(b_wrap), .ERR_CNT(b_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic smp(input logic [3:0] j);
    EN  = 1'b1;
    JIN = j;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    EN = 1'b1; JIN = 4'b0011;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if ({INDEX, VALID_CODE, LOCKED, STEP_ERR, WRAP, ERR_CNT} !== 15'd0) begin
      errors++; $display("FAIL reset_outs: got %h want 0", {INDEX, VALID_CODE, LOCKED, STEP_ERR, WRAP, ERR_CNT}); end
    checks++; if ({b_index, b_valid, b_locked, b_step, b_wrap, b_err} !== 9'd0) begin
      errors++; $display("FAIL reset_outs_w2: got %h want 0", {b_index, b_valid, b_locked, b_step, b_wrap, b_err}); end
    EN = 1'b0;
    @(negedge CLK);
    PRESET = 1'b0;
  endtask

  task automatic test_lock();
    for (int i = 0; i < 4; i++) begin
      smp(jc[i]);
      checks++; if (INDEX !== i[2:0]) begin
        errors++; $display("FAIL lock_index[%0d]: got %0d want %0d", i, INDEX, i); end
      checks++; if (LOCKED !== (i == 3)) begin
        errors++; $display("FAIL lock_locked[%0d]: got %b want %b", i, LOCKED, (i == 3)); end
      checks++; if ({VALID_CODE, STEP_ERR} !== 2'b10) begin
        errors++; $display("FAIL lock_valid_err[%0d]: got %b want 10", i, {VALID_CODE, STEP_ERR}); end
    end
    cur = 3;
  endtask

  task automatic test_wrap();
    for (int i = 4; i <= 8; i++) begin
      smp(jc[i % 8]);
      checks++; if (INDEX !== 3'(i % 8)) begin
        errors++; $display("FAIL wrap_index[%0d]: got %0d want %0d", i, INDEX, i % 8); end
      checks++; if ({LOCKED, WRAP} !== {1'b1, (i == 8)}) begin
        errors++; $display("FAIL wrap_pulse[%0d]: got %b want %b", i, {LOCKED, WRAP}, {1'b1, (i == 8)}); end
    end
    smp(jc[1]);
    checks++; if ({INDEX, LOCKED, WRAP} !== {3'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL wrap_after: got %b want 00110", {INDEX, LOCKED, WRAP}); end
    cur = 1;
  endtask

  task automatic test_illegal();
    smp(jc[2]);
    smp(jc[3]);
    checks++; if ({INDEX, LOCKED} !== {3'd3, 1'b1}) begin
      errors++; $display("FAIL ill_pre: got %b want 0111", {INDEX, LOCKED}); end
    smp(4'b0101);
    checks++; if ({VALID_CODE, STEP_ERR, LOCKED} !== 3'b010) begin
      errors++; $display("FAIL ill_flags: got %b want 010", {VALID_CODE, STEP_ERR, LOCKED}); end
    checks++; if (INDEX !== 3'd3) begin
      errors++; $display("FAIL ill_index: got %0d want 3", INDEX); end
    checks++; if (ERR_CNT !== 8'd1) begin
      errors++; $display("FAIL ill_errcnt: got %0d want 1", ERR_CNT); end
    smp(jc[3]);
    checks++; if ({VALID_CODE, STEP_ERR, LOCKED} !== 3'b100) begin
      errors++; $display("FAIL ill_after: got %b want 100", {VALID_CODE, STEP_ERR, LOCKED}); end
    checks++; if (b_err !== 2'd1) begin
      errors++; $display("FAIL ill_errcnt_w2: got %0d want 1", b_err); end
    cur = 3;
  endtask

  task automatic test_hold_bad_enable();
    for (int k = 0; k < 7; k++) begin
      cur = (cur + 1) % 8;
      smp(jc[cur]);
    end
    checks++; if ({INDEX, LOCKED} !== {3'd2, 1'b1}) begin
      errors++; $display("FAIL hold_pre: got %b want 0101", {INDEX, LOCKED}); end
    for (int k = 0; k < 3; k++) begin
      smp(jc[2]);
      checks++; if ({INDEX, LOCKED, STEP_ERR} !== {3'd2, 1'b1, 1'b0}) begin
        errors++; $display("FAIL hold[%0d]: got %b want 01010", k, {INDEX, LOCKED, STEP_ERR}); end
    end
    smp(4'b1111);
    checks++; if ({INDEX, LOCKED, STEP_ERR, VALID_CODE} !== {3'd4, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL bad_step: got %b want 100011", {INDEX, LOCKED, STEP_ERR, VALID_CODE}); end
    checks++; if (ERR_CNT !== 8'd2) begin
      errors++; $display("FAIL bad_errcnt: got %0d want 2", ERR_CNT); end
    cur = 4;
    EN = 1'b0; JIN = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      checks++; if ({INDEX, LOCKED, STEP_ERR, WRAP, VALID_CODE} !== {3'd4, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        errors++; $display("FAIL en_frozen[%0d]: got %b want 1000001", k, {INDEX, LOCKED, STEP_ERR, WRAP, VALID_CODE}); end
    end
  endtask

  task automatic test_err_sat();
    CLR_ERR = 1'b1; EN = 1'b0;
    @(posedge CLK); #1;
    CLR_ERR = 1'b0;
    checks++; if ({ERR_CNT, b_err} !== 10'd0) begin
      errors++; $display("FAIL clr_noen: got %0d/%0d want 0/0", ERR_CNT, b_err); end
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) begin
        cur = (cur + 1) % 8;
        smp(jc[cur]);
      end
      checks++; if (b_locked !== 1'b1) begin
        errors++; $display("FAIL sat_relock[%0d]: got %b want 1", k, b_locked); end
      smp(4'b0101);
      checks++; if (b_err !== ((k < 3) ? 2'(k + 1) : 2'd3)) begin
        errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, b_err, (k < 3) ? k + 1 : 3); end
    end
    checks++; if (ERR_CNT !== 8'd4) begin
      errors++; $display("FAIL sat_cnt8: got %0d want 4", ERR_CNT); end
    for (int s = 0; s < 3; s++) begin
      cur = (cur + 1) % 8;
      smp(jc[cur]);
    end
    CLR_ERR = 1'b1;
    smp(4'b0101);
    CLR_ERR = 1'b0;
    checks++; if ({STEP_ERR, ERR_CNT, b_err} !== {1'b1, 8'd0, 2'd0}) begin
      errors++; $display("FAIL clr_wins: got step=%b cnt=%0d/%0d want 1 0/0", STEP_ERR, ERR_CNT, b_err); end
  endtask

  task automatic test_midrun_reset();
    for (int s = 0; s < 3; s++) begin
      cur = (cur + 1) % 8;
      smp(jc[cur]);
    end
    checks++; if (LOCKED !== 1'b1) begin
      errors++; $display("FAIL mid_prelock: got %b want 1", LOCKED); end
    #2 PRESET = 1'b1;
    #1;
    checks++; if ({INDEX, VALID_CODE, LOCKED, STEP_ERR, WRAP, ERR_CNT} !== 15'd0) begin
      errors++; $display("FAIL mid_reset: got %h want 0", {INDEX, VALID_CODE, LOCKED, STEP_ERR, WRAP, ERR_CNT}); end
    checks++; if ({b_index, b_valid, b_locked, b_step, b_wrap, b_err} !== 9'd0) begin
      errors++; $display("FAIL mid_reset_w2: got %h want 0", {b_index, b_valid, b_locked, b_step, b_wrap, b_err}); end
    EN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    PRESET = 1'b0;
    smp(4'b0011);
    checks++; if ({INDEX, LOCKED, VALID_CODE, STEP_ERR} !== {3'd2, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mid_first: got %b want 010010", {INDEX, LOCKED, VALID_CODE, STEP_ERR}); end
    smp(4'b0111);
    checks++; if ({INDEX, LOCKED} !== {3'd3, 1'b0}) begin
      errors++; $display("FAIL mid_second: got %b want 0110", {INDEX, LOCKED}); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_illegal();
    test_hold_bad_enable();
    test_err_sat();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
